// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and oversampling default.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; idles high out of reset.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/receiver.sv
// 8N1 UART receiver, LSB first, sampling mid-bit on an oversampled rx_enb tick.
module receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_enb,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  logic w_rx_s;

  rx_sync u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rx_s)
  );

  uart_state_e   r_state, w_state_next;
  logic [CW-1:0] r_tick,  w_tick_next;
  logic [2:0]    r_idx,   w_idx_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [7:0]    r_data,  w_data_next;
  logic          r_done,  w_done_next;
  logic          r_ferr,  w_ferr_next;
  // Start detection is only armed once the line has been seen idle, so a
  // break after a framing error or a low line at reset release is ignored.
  logic          r_armed, w_armed_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tick  <= w_tick_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_done  <= w_done_next;
      r_ferr  <= w_ferr_next;
      r_armed <= w_armed_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_done_next  = 1'b0;
    w_ferr_next  = 1'b0;
    w_armed_next = r_armed;

    case (r_state)
      IDLE: begin
        if (rx_enb) begin
          if (w_rx_s) begin
            w_armed_next = 1'b1;
          end else if (r_armed) begin
            w_state_next = START;
            w_tick_next  = '0;
          end
        end
      end

      START: begin
        if (rx_enb) begin
          if (r_tick == HALF_M1) begin
            w_tick_next = '0;
            w_idx_next  = '0;
            // A start bit that is high again at its midpoint was a glitch.
            w_state_next = w_rx_s ? IDLE : DATA;
          end else begin
            w_tick_next = r_tick + CW'(1);
          end
        end
      end

      DATA: begin
        if (rx_enb) begin
          w_tick_next = r_tick + CW'(1);
          if (r_tick == FULL_M1) begin
            w_shift_next[r_idx] = w_rx_s;
            if (r_idx == 3'd7) begin
              w_state_next = STOP;
              w_tick_next  = '0;
            end else begin
              w_idx_next = r_idx + 3'd1;
            end
          end
        end
      end

      STOP: begin
        if (rx_enb) begin
          w_tick_next = r_tick + CW'(1);
          if (r_tick == FULL_M1) begin
            w_state_next = IDLE;
            w_tick_next  = '0;
            if (w_rx_s) begin
              w_data_next = r_shift;
              w_done_next = 1'b1;
            end else begin
              w_ferr_next  = 1'b1;
              w_armed_next = 1'b0;
            end
          end
        end
      end

      default: begin
        w_state_next = IDLE;
        w_tick_next  = '0;
        w_idx_next   = '0;
      end
    endcase
  end

  assign data_out  = r_data;
  assign rx_done   = r_done;
  assign frame_err = r_ferr;
  assign rx_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: bench serializer drives framed bytes, a queue of expected outcomes is checked every cycle.
`timescale 1ns/1ps
module tb_receiver;

  localparam int OS      = 16;
  localparam int BIT_CLK = 64;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       rx     = 1'b1;
  logic       rx_enb = 1'b0;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  receiver #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_enb    (rx_enb),
    .data_out  (data_out),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #10 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_ferr_seen = 0;
  bit         mon_en = 1'b0;
  bit         exp_kind[$];
  logic [7:0] exp_data[$];
  logic [7:0] rx_log[$];
  logic [7:0] tx_log[$];
  logic [7:0] model_last = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Baud generator stand-in: one tick every 4 clocks.
  initial begin : enb_gen
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      rx_enb = (k % 4 == 0);
    end
  end

  // Compare process: any pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("pulse_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
      if (rx_done) begin
        chk("done_expected", {31'd0, (exp_kind.size() > 0 && exp_kind[0] == 1'b0)}, 32'd1);
        if (exp_kind.size() > 0 && exp_kind[0] == 1'b0) begin
          chk("done_data", {24'd0, data_out}, {24'd0, exp_data[0]});
          model_last = exp_data[0];
          void'(exp_kind.pop_front());
          void'(exp_data.pop_front());
        end
        rx_log.push_back(data_out);
      end
      if (frame_err) begin
        n_ferr_seen++;
        chk("ferr_expected", {31'd0, (exp_kind.size() > 0 && exp_kind[0] == 1'b1)}, 32'd1);
        if (exp_kind.size() > 0 && exp_kind[0] == 1'b1) begin
          void'(exp_kind.pop_front());
          void'(exp_data.pop_front());
        end
      end
      chk("data_out_hold", {24'd0, data_out}, {24'd0, model_last});
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_kind.push_back(!stop_ok);
    exp_data.push_back(b);
    rx = 1'b0;
    wait_clks(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLK);
    end
    rx = stop_ok;
    wait_clks(BIT_CLK);
    if (stop_ok) tx_log.push_back(b);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 400 && exp_kind.size() > 0; i++) wait_clks(1);
    chk(nm, exp_kind.size(), 32'd0);
  endtask

  initial begin : main
    int rx_base;
    int n_good;
    logic [7:0] rb;
    bit ok;

    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_clks(4);
    chk("rst_data_out", {24'd0, data_out}, 32'h00);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("rst_done", {31'd0, rx_done}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    wait_clks(100);

    // Single good byte.
    send_frame(8'h6B, 1'b1);
    rx = 1'b1;
    wait_clks(40);
    drain("t1_drain");
    chk("t1_data", {24'd0, data_out}, 32'h6B);
    chk("t1_count", rx_log.size(), 32'd1);

    // Short glitch in idle.
    rx = 1'b0;
    wait_clks(12);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
    wait_clks(12);
    rx = 1'b1;
    wait_clks(48);
    chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
    chk("glitch_nodone", rx_log.size(), 32'd1);

    // Bad stop bit followed by a two-frame break.
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    wait_clks(2 * 10 * BIT_CLK);
    rx = 1'b1;
    wait_clks(128);
    drain("brk_drain");
    chk("brk_one_ferr", n_ferr_seen, 32'd1);
    chk("brk_data_kept", {24'd0, data_out}, 32'h6B);
    chk("brk_nodone", rx_log.size(), 32'd1);

    // Back-to-back frames, no idle between them.
    send_frame(8'hCC, 1'b1);
    send_frame(8'h00, 1'b1);
    rx = 1'b1;
    wait_clks(40);
    drain("b2b_drain");
    chk("b2b_first", {24'd0, rx_log[1]}, 32'hCC);
    chk("b2b_second", {24'd0, rx_log[2]}, 32'h00);

    // Reset in the middle of the data bits of 0xA5.
    rb = 8'hA5;
    rx = 1'b0;
    wait_clks(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      wait_clks(BIT_CLK);
    end
    rst = 1'b1;
    rx = 1'b1;
    model_last = 8'h00;
    wait_clks(3);
    rst = 1'b0;
    chk("rst_mid_data_out", {24'd0, data_out}, 32'h00);
    chk("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
    wait_clks(100);
    rx_base = rx_log.size();
    send_frame(8'h3C, 1'b1);
    rx = 1'b1;
    wait_clks(40);
    drain("rst_drain");
    chk("rst_next_data", {24'd0, data_out}, 32'h3C);
    chk("rst_one_done", rx_log.size() - rx_base, 32'd1);

    // Loopback: received bytes in the order the serializer finished them.
    tx_log.delete();
    rx_base = rx_log.size();
    send_frame(8'h6B, 1'b1);
    send_frame(8'hCC, 1'b1);
    rx = 1'b1;
    wait_clks(40);
    drain("loop_drain");
    chk("loop_count", rx_log.size() - rx_base, tx_log.size());
    for (int i = 0; i < 2; i++)
      chk("loop_match", {24'd0, rx_log[rx_base + i]}, {24'd0, tx_log[i]});

    // Randomized frames, gaps and framing errors.
    rx_base = rx_log.size();
    n_good = 0;
    for (int f = 0; f < 24; f++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(rb, ok);
      rx = 1'b1;
      if (ok) begin
        n_good++;
        wait_clks($urandom_range(0, 100));
      end else begin
        wait_clks(BIT_CLK + $urandom_range(0, 100));
      end
    end
    wait_clks(40);
    drain("rand_drain");
    chk("rand_count", rx_log.size() - rx_base, n_good);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16, meaning rx_enb ticks per bit period; SHALL be a power of two, minimum 8.
REQ-002 clk  input  1  single clock domain; all state SHALL update on rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rx  input  1  serial line, asynchronous to clk, idle high, 8N1 LSB-first.
REQ-005 rx_enb  input  1  one-clk-wide oversample tick from the baud generator (Rx_en), OVERSAMPLE ticks per bit.
REQ-006 data_out  output  8  last received byte.
REQ-007 rx_done  output  1  one-clk pulse: valid byte in data_out.
REQ-008 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-009 rx_busy  output  1  high in any state other than IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rx_s.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP; the tick counter (log2(OVERSAMPLE) bits) and bit index (3 bits) advance only on cycles with rx_enb=1.
REQ-012 IDLE: on an rx_enb tick with rx_s=0 -> START, tick counter cleared to 0.
REQ-013 START: at tick count OVERSAMPLE/2-1 (mid start bit), rx_s=0 -> DATA with counter and index cleared; rx_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: every OVERSAMPLE ticks (mid-bit), rx_s SHALL be shifted into the shift register at position index, LSB first; after index 7 -> STOP, counter cleared.
REQ-015 STOP: after OVERSAMPLE ticks sample rx_s; 1 -> data_out <= shift register, rx_done=1 for exactly one clk, -> IDLE.
REQ-016 STOP with rx_s=0 -> frame_err=1 for exactly one clk, data_out unchanged, rx_done stays 0, -> IDLE.
REQ-017 After a framing error, IDLE SHALL NOT re-arm until rx_s has been seen high on at least one rx_enb tick (break condition yields one frame_err only).
REQ-018 rx_done and frame_err SHALL default to 0 every cycle and never be high together.
REQ-019 Latency: rx_done asserts on the clk following the mid-stop-bit rx_enb tick; data_out is stable from that cycle until the next rx_done.
REQ-020 Counter wrap: tick counter wraps OVERSAMPLE-1 -> 0 naturally; no other wrap permitted.
REQ-021 rx_enb held low SHALL freeze the FSM, counters and outputs (except pulse clearing).
REQ-022 Illegal state encoding SHALL return to IDLE on the next clk.

Reset
REQ-023 rst=1 at a rising edge SHALL force: state IDLE, counters 0, shift register 0, data_out 0x00, rx_done 0, frame_err 0, rx_busy 0, synchronizer flops 1.
REQ-024 rst mid-frame SHALL abort the frame with no rx_done/frame_err pulse; reception resumes on the next falling edge of rx_s after rst deasserts.

Structure
REQ-025 Shared package uart_pkg SHALL hold the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the OVERSAMPLE default, shared with the transmitter.
REQ-026 One sub-module rx_sync (2-flop synchronizer, reset value 1) SHALL be instantiated; everything else stays in receiver.

Verification (bench: clk 50 MHz, rx_enb every 4 clks, bit period 64 clks, driven by a bench serializer)
REQ-027 Send 0x6B with valid stop -> exactly one rx_done pulse, data_out=0x6B, frame_err never high.
REQ-028 Back-to-back 0xCC then 0x00 with no idle gap -> two rx_done pulses, data_out 0xCC then 0x00.
REQ-029 rx low for 24 clks (under half a bit) in IDLE -> back to IDLE, no pulses, rx_busy drops.
REQ-030 0x55 with stop bit driven 0, then line held low 2 frames -> one frame_err pulse, data_out keeps prior value, no rx_done.
REQ-031 rst asserted mid-DATA of 0xA5, then 0x3C sent -> no pulse for 0xA5, rx_done with data_out=0x3C.
REQ-032 Loopback with transmitter sending 0x6B, 0xCC -> rx_done data matches each tx_done in order.
